bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It sits directly upstream of the per-digit 7-segment decoders on the DE1-SoC. It takes a binary count, such as a counter or switch value, and produces packed BCD nibbles, one per HEX display. A start/busy/done handshake lets slow or multi-cycle producers hand over a value and know exactly when the digits are stable.

---
 rtl/bin2bcd_pkg.sv | 25 ++
 rtl/bin2bcd_seq_if.sv | 15 +
 rtl/bin2bcd_seq_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 117 +++++++++++
 tb/tb_bin2bcd_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter:
// FSM state encoding, digit-adjust constants and the saturation limit helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int         DIGITS_DEF = 6;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD    = 4'd3;

    // Largest value representable in 'digits' BCD digits, i.e. 10^digits - 1.
    function automatic longint unsigned bcd_limit(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and data bus between a producer and bin2bcd_seq.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 20,
    parameter int DIGITS = 6
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    modport master (output start, bin_in, input busy, done, bcd_out, ovf);
    modport slave  (input start, bin_in, output busy, done, bcd_out, ovf);
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Per-digit double-dabble correction: a digit of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= ADJ_THRESH) ? (i_digit + ADJ_ADD) : i_digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
// Optional saturation to all nines is compiled in with `define BIN2BCD_SAT_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_t              r_state, w_state_nxt;
    logic [WIDTH-1:0]    r_shift, w_shift_nxt;
    logic [BW-1:0]       r_scratch, w_scratch_nxt;
    logic [CW-1:0]       r_cnt, w_cnt_nxt;
    logic                r_sat, w_sat_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [BW-1:0]       r_bcd, w_bcd_nxt;
    logic                r_ovf, w_ovf_nxt;

    logic [BW-1:0]       w_adj;
    logic [BW+WIDTH-1:0] w_shifted;
    logic                w_sat_in;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
        );
    end

    // The scratch MSB falls off the top, which yields the value mod 10^DIGITS.
    assign w_shifted = {w_adj, r_shift} << 1;

`ifdef BIN2BCD_SAT_EN
    localparam longint unsigned LIMIT = bcd_limit(DIGITS);
    assign w_sat_in = (64'(bus.bin_in) > LIMIT);
`else
    assign w_sat_in = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_sat_nxt     = r_sat;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_bcd_nxt     = r_bcd;
        w_ovf_nxt     = r_ovf;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_shift_nxt   = bus.bin_in;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_sat_nxt     = w_sat_in;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                {w_scratch_nxt, w_shift_nxt} = w_shifted;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_bcd_nxt   = r_sat ? {DIGITS{4'h9}} : r_scratch;
                w_ovf_nxt   = r_sat;
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_sat     <= w_sat_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_bcd     <= w_bcd_nxt;
            r_ovf     <= w_ovf_nxt;
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.bcd_out = r_bcd;
    assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a driver pushes expected results computed
// with plain decimal arithmetic; a monitor pops and checks on every done pulse.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 6;
    localparam int LAT    = WIDTH + 1;

    typedef struct {
        logic [23:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t q[$];

    bin2bcd_seq_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit over_limit(input int unsigned v);
        return v > 999999;
    endfunction

    function automatic logic [23:0] model_bcd(input int unsigned v);
        int unsigned x;
        logic [23:0] r;
`ifdef BIN2BCD_SAT_EN
        x = over_limit(v) ? 999999 : v;
`else
        x = v % 1000000;
`endif
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input int unsigned v);
`ifdef BIN2BCD_SAT_EN
        return over_limit(v);
`else
        return 1'b0;
`endif
    endfunction

    // Accepts v on the next edge, then stays until done is visible, so the
    // following call re-asserts start in the cycle that done is high.
    task automatic issue(input logic [19:0] v, input bit glitch);
        exp_t e;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = v;
        @(posedge clk);
        #1;
        e.bcd = model_bcd(int'(v));
        e.ovf = model_ovf(int'(v));
        e.cyc = cyc + LAT;
        q.push_back(e);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            chk("busy_hold", 64'(bus.busy), 64'd1);
            bus.start  = glitch && (i == 3 || i == 10);
            bus.bin_in = 20'($urandom);
            @(posedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                chk("bcd_out", 64'(bus.bcd_out), 64'(e.bcd));
                chk("ovf", 64'(bus.ovf), 64'(e.ovf));
                chk("latency", 64'(cyc), 64'(e.cyc));
                chk("busy_at_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        reset = 1'b0;

        issue(20'd0, 1'b0);
        issue(20'd123456, 1'b0);
        issue(20'd999999, 1'b0);
        issue(20'd1000000, 1'b0);
        issue(20'd1000001, 1'b0);
        issue(20'd1048575, 1'b0);
        issue(20'd7, 1'b0);
        issue(20'd654321, 1'b1);
        issue(20'd123456, 1'b0);

        // Abort a conversion so the reset lands on its tenth shift edge.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 20'd777777;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_bcd", 64'(bus.bcd_out), 64'd0);
        chk("abort_ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(posedge clk);
        issue(20'd42, 1'b0);

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
            end
            issue(20'($urandom_range(0, 20'hFFFFF)), ($urandom_range(0, 4) == 0));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
